// File: rtl/acq_write_ctrl.sv
// Acquisition write controller: sequences one capture through the 4-channel
// 16-to-128-bit sample combiner. It drives the combiner enable, strobes each
// completed 128-bit word into the sample FIFO with a wrapping word address,
// and runs the pre-trigger fill / trigger wait / post-trigger count sequence.
module acq_write_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic [ADDR_W-1:0] pre_depth,
  input  logic [ADDR_W-1:0] post_depth,
  input  logic              fifo_full,
  output logic              comb_wen,
  output logic              fifo_wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic              fifo_wr_q;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] pre_depth_q, pre_depth_d;
  logic [ADDR_W-1:0] post_depth_q, post_depth_d;

  logic capturing;
  logic stall;
  logic wen;

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, combiner enable, counters and address bookkeeping.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    overflow_d   = overflow_q;
    wr_addr_d    = wr_addr_q;
    trig_addr_d  = trig_addr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    pre_depth_d  = pre_depth_q;
    post_depth_d = post_depth_q;

    capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
    // Never open a new word into a full FIFO; a word already half captured
    // (phase 1) is always finished so the combiner never holds a stale half.
    stall     = capturing && !phase_q && fifo_full;
    wen       = capturing && !stall;

    if (wen) begin
      phase_d = ~phase_q;
    end
    if (stall) begin
      overflow_d = 1'b1;
    end
    // Address advances after every strobe, including one that drains after abort.
    if (fifo_wr_q) begin
      wr_addr_d = wr_addr_q + ADDR_W'(1);
    end

    if (abort) begin
      state_d = S_IDLE;
      phase_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_d      = S_PRE;
            pre_depth_d  = pre_depth;
            post_depth_d = (post_depth == '0) ? ADDR_W'(1) : post_depth;
            wr_addr_d    = '0;
            pre_cnt_d    = '0;
            post_cnt_d   = '0;
            overflow_d   = 1'b0;
          end
        end
        S_PRE: begin
          if (fifo_wr_q) begin
            pre_cnt_d = pre_cnt_q + ADDR_W'(1);
          end
          if (pre_cnt_q == pre_depth_q) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (trig) begin
            state_d = S_POST;
          end
        end
        S_POST: begin
          if (fifo_wr_q) begin
            if (post_cnt_q == '0) begin
              trig_addr_d = wr_addr_q;
            end
            post_cnt_d = post_cnt_q + ADDR_W'(1);
            if (post_cnt_q + ADDR_W'(1) == post_depth_q) begin
              // Any half word opened on this last cycle is discarded.
              state_d = S_DONE;
              phase_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          phase_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers; the strobe is registered to line up with the combiner output.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      phase_q      <= 1'b0;
      fifo_wr_q    <= 1'b0;
      overflow_q   <= 1'b0;
      wr_addr_q    <= '0;
      trig_addr_q  <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      pre_depth_q  <= '0;
      post_depth_q <= '0;
    end else begin
      phase_q      <= phase_d;
      fifo_wr_q    <= wen && phase_q;
      overflow_q   <= overflow_d;
      wr_addr_q    <= wr_addr_d;
      trig_addr_q  <= trig_addr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      pre_depth_q  <= pre_depth_d;
      post_depth_q <= post_depth_d;
    end
  end

  assign comb_wen  = wen;
  assign fifo_wr   = fifo_wr_q;
  assign wr_addr   = wr_addr_q;
  assign trig_addr = trig_addr_q;
  assign busy      = capturing;
  assign done      = (state_q == S_DONE);
  assign overflow  = overflow_q;

endmodule
